// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, states,
// instruction classes and the datapath select codes.
package ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LUI,
        CLS_AUIPC,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR
    } instr_cls_e;

    localparam logic [1:0] PCSEL_PC4   = 2'b00;
    localparam logic [1:0] PCSEL_PCIMM = 2'b01;
    localparam logic [1:0] PCSEL_ALU   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_instr_legal_chk.sv
// Combinational RV32I legality check: classifies opcode and rejects
// unsupported opcodes and reserved funct3 values.
module instr_legal_chk
    import ctrl_pkg::*;
(
    input  logic [6:0]  iOpcode,
    input  logic [2:0]  iFunct3,
    output logic        oLegal,
    output instr_cls_e  oCls
);

    always_comb begin
        oLegal = 1'b1;
        oCls   = CLS_NONE;
        case (iOpcode)
            OPC_OP:     oCls = CLS_ALU_R;
            OPC_OP_IMM: oCls = CLS_ALU_I;
            OPC_LUI:    oCls = CLS_LUI;
            OPC_AUIPC:  oCls = CLS_AUIPC;
            OPC_JAL:    oCls = CLS_JAL;
            OPC_LOAD: begin
                oCls   = CLS_LOAD;
                oLegal = !(iFunct3 == 3'd3 || iFunct3 == 3'd6 || iFunct3 == 3'd7);
            end
            OPC_STORE: begin
                oCls   = CLS_STORE;
                oLegal = (iFunct3 <= 3'd2);
            end
            OPC_BRANCH: begin
                oCls   = CLS_BRANCH;
                oLegal = !(iFunct3 == 3'd2 || iFunct3 == 3'd3);
            end
            OPC_JALR: begin
                oCls   = CLS_JALR;
                oLegal = (iFunct3 == 3'd0);
            end
            default:    oLegal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback,
// drives datapath enables/selects, traps illegal instructions, counts retires.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
)
(
    input  logic             iClk,
    input  logic             iRstN,
    input  logic [6:0]       iOpcode,
    input  logic [2:0]       iFunct3,
    input  logic             iBrTaken,
    input  logic             iMemReady,
    output logic             oMemReq,
    output logic             oMemWe,
    output logic             oMemInstr,
    output logic             oIrWe,
    output logic             oPcWe,
    output logic [1:0]       oPcSel,
    output logic             oAluSrcA,
    output logic             oAluSrcB,
    output logic [1:0]       oAluOp,
    output logic             oRegWe,
    output logic [1:0]       oWbSel,
    output logic             oRetire,
    output logic [CNT_W-1:0] oRetireCnt,
    output logic             oIllegal,
    output logic [2:0]       oState
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    instr_cls_e        cls_q, cls_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic       legal;
    instr_cls_e dec_cls;
    logic       timeout;
    logic       mem_req, mem_we, mem_instr, ir_we, pc_we;
    logic       src_a, src_b, reg_we, retire, illegal;
    logic [1:0] pc_sel, alu_op, wb_sel;

    instr_legal_chk u_legal (
        .iOpcode (iOpcode),
        .iFunct3 (iFunct3),
        .oLegal  (legal),
        .oCls    (dec_cls)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_NONE;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    // Fires on the wait cycle that would make the outstanding request MEM_TIMEOUT cycles old.
    assign timeout = (MEM_TIMEOUT > 0) && !iMemReady && (int'(wait_q) + 1 >= MEM_TIMEOUT);

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        cnt_d     = cnt_q;
        wait_d    = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_instr = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PCSEL_PC4;
        src_a     = 1'b0;
        src_b     = 1'b0;
        alu_op    = ALUOP_ADD;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        retire    = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                mem_instr = 1'b1;
                if (iMemReady) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DECODE: begin
                cls_d   = dec_cls;
                state_d = legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                state_d = ST_WB;
                case (cls_q)
                    CLS_ALU_R: alu_op = ALUOP_FUNCT;
                    CLS_ALU_I: begin
                        src_b  = 1'b1;
                        alu_op = ALUOP_FUNCT;
                    end
                    CLS_LUI: ;
                    CLS_AUIPC: begin
                        src_a = 1'b1;
                        src_b = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        src_b   = 1'b1;
                        state_d = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op  = ALUOP_SUB;
                        pc_we   = 1'b1;
                        pc_sel  = iBrTaken ? PCSEL_PCIMM : PCSEL_PC4;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_JAL: begin
                        pc_we  = 1'b1;
                        pc_sel = PCSEL_PCIMM;
                    end
                    CLS_JALR: begin
                        src_b  = 1'b1;
                        pc_we  = 1'b1;
                        pc_sel = PCSEL_ALU;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                // Address comes from the ALU, so the EXEC selects stay put for the whole request.
                mem_req = 1'b1;
                mem_we  = (cls_q == CLS_STORE);
                src_b   = 1'b1;
                if (iMemReady) begin
                    if (cls_q == CLS_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
                pc_we   = !(cls_q == CLS_JAL || cls_q == CLS_JALR);
                case (cls_q)
                    CLS_LOAD:          wb_sel = WB_MEM;
                    CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                    CLS_LUI:           wb_sel = WB_IMM;
                    default:           wb_sel = WB_ALU;
                endcase
            end
            ST_TRAP: illegal = 1'b1;
            default: state_d = ST_TRAP;
        endcase

        if (retire) cnt_d = cnt_q + 1'b1;
    end

    // Gating with iRstN drops an in-flight request the moment reset asserts.
    assign oMemReq    = mem_req & iRstN;
    assign oMemWe     = mem_we & iRstN;
    assign oMemInstr  = mem_instr & iRstN;
    assign oIrWe      = ir_we & iRstN;
    assign oPcWe      = pc_we & iRstN;
    assign oPcSel     = pc_sel & {2{iRstN}};
    assign oAluSrcA   = src_a & iRstN;
    assign oAluSrcB   = src_b & iRstN;
    assign oAluOp     = alu_op & {2{iRstN}};
    assign oRegWe     = reg_we & iRstN;
    assign oWbSel     = wb_sel & {2{iRstN}};
    assign oRetire    = retire & iRstN;
    assign oIllegal   = illegal & iRstN;
    assign oRetireCnt = cnt_q;
    assign oState     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, memory
// waits, reset abort, illegal traps and retire-counter wrap (CNT_W=4).
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             iClk = 1'b0;
    logic             iRstN = 1'b0;
    logic [6:0]       iOpcode = '0;
    logic [2:0]       iFunct3 = '0;
    logic             iBrTaken = 1'b0;
    logic             iMemReady = 1'b0;
    logic             oMemReq, oMemWe, oMemInstr, oIrWe, oPcWe;
    logic [1:0]       oPcSel, oAluOp, oWbSel;
    logic             oAluSrcA, oAluSrcB, oRegWe, oRetire, oIllegal;
    logic [CNT_W-1:0] oRetireCnt;
    logic [2:0]       oState;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(0)) dut (
        .iClk       (iClk),
        .iRstN      (iRstN),
        .iOpcode    (iOpcode),
        .iFunct3    (iFunct3),
        .iBrTaken   (iBrTaken),
        .iMemReady  (iMemReady),
        .oMemReq    (oMemReq),
        .oMemWe     (oMemWe),
        .oMemInstr  (oMemInstr),
        .oIrWe      (oIrWe),
        .oPcWe      (oPcWe),
        .oPcSel     (oPcSel),
        .oAluSrcA   (oAluSrcA),
        .oAluSrcB   (oAluSrcB),
        .oAluOp     (oAluOp),
        .oRegWe     (oRegWe),
        .oWbSel     (oWbSel),
        .oRetire    (oRetire),
        .oRetireCnt (oRetireCnt),
        .oIllegal   (oIllegal),
        .oState     (oState)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    // Zero-wait fetch then decode; returns one cycle into EXEC (or TRAP).
    task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3);
        iOpcode   = op;
        iFunct3   = f3;
        iMemReady = 1'b1;
        #1;
        chk("fetch_state", oState, 0);
        chk("fetch_req", {oMemReq, oMemInstr, oIrWe}, 3'b111);
        step();
        chk("decode_state", oState, 1);
        step();
    endtask

    task automatic rst_pulse();
        iRstN = 1'b0;
        #2;
        iRstN = 1'b1;
        #1;
    endtask

    task automatic illegal_case(input string tag, input logic [6:0] op, input logic [2:0] f3);
        rst_pulse();
        fetch_decode(op, f3);
        chk(tag, {oState, oIllegal}, {3'd5, 1'b1});
    endtask

    initial begin
        // Reset: FETCH state but every output held low.
        #3;
        chk("rst_memreq", oMemReq, 0);
        chk("rst_irwe_meminstr", {oIrWe, oMemInstr}, 0);
        chk("rst_state", oState, 0);
        chk("rst_cnt", oRetireCnt, 0);
        step(2);
        iRstN = 1'b1;

        // ADDI x1,x0,5
        fetch_decode(7'b0010011, 3'd0);
        chk("addi_exec", {oState, oAluSrcA, oAluSrcB, oAluOp, oRegWe}, {3'd2, 1'b0, 1'b1, 2'b10, 1'b0});
        step();
        chk("addi_wb", {oState, oRegWe, oWbSel, oRetire, oPcWe, oPcSel}, {3'd4, 1'b1, 2'b00, 1'b1, 1'b1, 2'b00});
        step();
        chk("addi_cnt", {oState, oRetireCnt}, {3'd0, 4'd1});

        // LW with two wait cycles on the data access
        fetch_decode(7'b0000011, 3'd2);
        iMemReady = 1'b0;
        #1;
        chk("lw_exec", {oState, oAluSrcA, oAluSrcB, oAluOp, oMemReq}, {3'd2, 1'b0, 1'b1, 2'b00, 1'b0});
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) iMemReady = 1'b1;
            #1;
            chk("lw_mem", {oState, oMemReq, oMemWe, oMemInstr, oRetire, oAluSrcB}, {3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
            step();
        end
        chk("lw_wb", {oState, oRegWe, oWbSel, oPcWe}, {3'd4, 1'b1, 2'b01, 1'b1});
        step();
        chk("lw_cnt", {oState, oRetireCnt}, {3'd0, 4'd2});

        // BEQ taken / not taken
        fetch_decode(7'b1100011, 3'd0);
        iBrTaken = 1'b1;
        #1;
        chk("beq_t_exec", {oState, oPcWe, oPcSel, oRegWe, oRetire, oAluOp}, {3'd2, 1'b1, 2'b01, 1'b0, 1'b1, 2'b01});
        step();
        chk("beq_t_cnt", {oState, oRetireCnt}, {3'd0, 4'd3});
        fetch_decode(7'b1100011, 3'd0);
        iBrTaken = 1'b0;
        #1;
        chk("beq_nt_exec", {oPcWe, oPcSel, oRegWe, oRetire}, {1'b1, 2'b00, 1'b0, 1'b1});
        step();
        chk("beq_nt_cnt", {oState, oRetireCnt}, {3'd0, 4'd4});

        // LUI
        fetch_decode(7'b0110111, 3'd0);
        chk("lui_exec", {oState, oPcWe}, {3'd2, 1'b0});
        step();
        chk("lui_wb", {oRegWe, oWbSel, oPcWe, oPcSel}, {1'b1, 2'b11, 1'b1, 2'b00});
        step();
        // JAL
        fetch_decode(7'b1101111, 3'd0);
        chk("jal_exec", {oPcWe, oPcSel, oRegWe}, {1'b1, 2'b01, 1'b0});
        step();
        chk("jal_wb", {oState, oRegWe, oWbSel, oPcWe}, {3'd4, 1'b1, 2'b10, 1'b0});
        step();
        // JALR
        fetch_decode(7'b1100111, 3'd0);
        chk("jalr_exec", {oAluSrcA, oAluSrcB, oAluOp, oPcWe, oPcSel}, {1'b0, 1'b1, 2'b00, 1'b1, 2'b10});
        step();
        chk("jalr_wb", {oRegWe, oWbSel, oPcWe, oRetire}, {1'b1, 2'b10, 1'b0, 1'b1});
        step();
        // AUIPC
        fetch_decode(7'b0010111, 3'd0);
        chk("auipc_exec", {oAluSrcA, oAluSrcB, oAluOp}, {1'b1, 1'b1, 2'b00});
        step();
        chk("auipc_wb", {oRegWe, oWbSel, oPcWe}, {1'b1, 2'b00, 1'b1});
        step();
        chk("mix_cnt", {oState, oRetireCnt}, {3'd0, 4'd8});

        // SW zero-wait: retires from MEM
        fetch_decode(7'b0100011, 3'd2);
        step();
        chk("sw_mem", {oState, oMemReq, oMemWe, oMemInstr, oPcWe, oPcSel, oRetire}, {3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1});
        step();
        chk("sw_cnt", {oState, oRetireCnt}, {3'd0, 4'd9});

        // SW aborted by reset mid-MEM
        fetch_decode(7'b0100011, 3'd2);
        iMemReady = 1'b0;
        step();
        chk("swrst_mem", {oState, oMemReq, oMemWe}, {3'd3, 1'b1, 1'b1});
        #2;
        iRstN = 1'b0;
        #1;
        chk("swrst_drop", {oMemReq, oMemWe, oRetire}, 3'b000);
        chk("swrst_cnt", {oState, oRetireCnt}, {3'd0, 4'd0});
        #3;
        iRstN = 1'b1;
        #1;
        chk("swrst_refetch", {oState, oMemReq, oMemInstr, oRetireCnt}, {3'd0, 1'b1, 1'b1, 4'd0});

        // Counter wrap: 15 retires reach all-ones, the 16th returns to 0
        for (int i = 0; i < 15; i++) begin
            fetch_decode(7'b0110011, 3'd0);
            step(2);
        end
        chk("wrap_full", oRetireCnt, 4'hF);
        fetch_decode(7'b0110011, 3'd0);
        step();
        chk("wrap_retire", {oState, oRetire}, {3'd4, 1'b1});
        step();
        chk("wrap_zero", oRetireCnt, 4'h0);

        // Illegal opcode: TRAP is sticky and never requests memory
        fetch_decode(7'b1111111, 3'd0);
        for (int i = 0; i < 20; i++) begin
            chk("trap_hold", {oState, oIllegal, oMemReq, oPcWe, oRegWe, oRetire}, {3'd5, 1'b1, 4'b0000});
            step();
        end
        rst_pulse();
        chk("trap_cleared", {oState, oIllegal}, {3'd0, 1'b0});
        fetch_decode(7'b0000011, 3'd3);
        for (int i = 0; i < 20; i++) begin
            chk("ld3_trap", {oState, oIllegal, oMemReq}, {3'd5, 1'b1, 1'b0});
            step();
        end
        illegal_case("ld6_trap", 7'b0000011, 3'd6);
        illegal_case("st3_trap", 7'b0100011, 3'd3);
        illegal_case("br2_trap", 7'b1100011, 3'd2);
        illegal_case("jalr1_trap", 7'b1100111, 3'd1);
        rst_pulse();
        fetch_decode(7'b0000011, 3'd5);
        chk("lhu_legal", {oState, oIllegal}, {3'd2, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle RV32I control FSM that sequences the instruction decoder, ALU, register file, PC and the shared instruction/data memory port.
- Consumes the decoder's opcode/funct3 fields and the datapath branch comparator result.
- Issues one memory request at a time, with a ready handshake.
- Drives all datapath enables and selects, flags illegal instructions and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 0, cycles waited for iMemReady before trapping; 0 disables the timeout.

Ports:
- iClk  input  1  clock, rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iOpcode  input  7  opcode field from the decoder.
- iFunct3  input  3  funct3 field from the decoder.
- iBrTaken  input  1  datapath branch comparator result, valid in EXEC.
- iMemReady  input  1  memory completes the current request this cycle.
- oMemReq  output  1  memory request valid.
- oMemWe  output  1  store request (meaningful only with oMemReq).
- oMemInstr  output  1  address select: 1 = PC (fetch), 0 = ALU result (data).
- oIrWe  output  1  latch IR and PC_old.
- oPcWe  output  1  PC write enable.
- oPcSel  output  2  00 PC_old+4, 01 PC_old+imm, 10 ALU result with bit0 cleared.
- oAluSrcA  output  1  0 rs1, 1 PC_old.
- oAluSrcB  output  1  0 rs2, 1 imm.
- oAluOp  output  2  00 ADD, 01 SUB/compare, 10 funct-decoded.
- oRegWe  output  1  register file write enable.
- oWbSel  output  2  00 ALU, 01 memory data, 10 PC_old+4, 11 imm.
- oRetire  output  1  one-cycle pulse on the final cycle of each instruction.
- oRetireCnt  output  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.
- oIllegal  output  1  sticky trap flag.
- oState  output  3  current state, for debug.

Behaviour:
- Reset (async, iRstN=0):
  - state=FETCH; every output 0; oRetireCnt=0.
  - A request in flight is abandoned (oMemReq drops asynchronously). Memory must tolerate the abort.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP.
- Handshake: a request is held (oMemReq=1, stable controls) until iMemReady=1 is sampled on a rising edge. The transfer completes in that cycle. iMemReady while oMemReq=0 is ignored.
- FETCH:
  - oMemReq=1, oMemInstr=1.
  - On iMemReady: oIrWe=1, go DECODE. Otherwise stay.
- DECODE (1 cycle):
  - Legality check on iOpcode/iFunct3. Illegal -> TRAP, otherwise -> EXEC.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111.
  - Additionally illegal: load funct3 in {3,6,7}; store funct3>2; branch funct3 in {2,3}; JALR funct3!=0.
- EXEC (1 cycle), by instruction class:
  - R/I-ALU: SrcA=0, SrcB=(I?1:0), AluOp=10 -> WB.
  - LUI: -> WB.
  - AUIPC: SrcA=1, SrcB=1, AluOp=00 -> WB.
  - Load/store: SrcA=0, SrcB=1, AluOp=00 -> MEM.
  - Branch: AluOp=01, oPcWe=1, oPcSel=iBrTaken?01:00, oRetire=1 -> FETCH.
  - JAL: oPcWe=1, oPcSel=01 -> WB.
  - JALR: SrcA=0, SrcB=1, AluOp=00, oPcWe=1, oPcSel=10 -> WB.
- MEM:
  - oMemReq=1, oMemInstr=0, oMemWe=store; ALU selects held from EXEC.
  - On iMemReady, store: oPcWe=1, oPcSel=00, oRetire=1 -> FETCH.
  - On iMemReady, load: -> WB.
- WB (1 cycle):
  - oRegWe=1.
  - oWbSel: ALU/AUIPC 00, load 01, JAL/JALR 10, LUI 11.
  - PC update: oPcWe=1 with oPcSel=00, except JAL/JALR (PC already written in EXEC).
  - oRetire=1 -> FETCH.
- TRAP:
  - oIllegal=1; all enables and requests 0; stay until reset.
  - Entered from DECODE on an illegal instruction.
  - Entered from FETCH/MEM when MEM_TIMEOUT>0 and the wait counter reaches MEM_TIMEOUT.
- Latency with zero-wait memory: ALU/LUI/AUIPC/JAL/JALR 4 cycles; load 5; store 4; branch 3. Each memory wait cycle adds 1.
- oRetireCnt increments on the edge that ends each oRetire cycle; it wraps from all-ones to 0.
- oRd=x0 writes are not suppressed here; the register file ignores them.

Decomposition:
- Package ctrl_pkg holds: opcode localparams, state encoding, and the oPcSel/oWbSel/oAluOp encodings.
- One sub-module, instr_legal_chk: combinational legality check on opcode+funct3 producing legal and class outputs.

Test Plan:
- ADDI 0x00500093, iMemReady=1 always -> states 0,1,2,4; oRegWe=1, oWbSel=00 in cycle 4; oRetireCnt=1.
- LW 0x0000A103, data iMemReady delayed 2 cycles -> MEM held 3 cycles with oMemWe=0, oMemReq=1; WB oWbSel=01; total 7 cycles.
- BEQ 0x00000463:
  - iBrTaken=1 -> cycle 3 oPcWe=1, oPcSel=01, no oRegWe.
  - iBrTaken=0 -> oPcSel=00.
- Illegal 0x0000007F, and load with funct3=3 (0x00003003) -> TRAP; oIllegal=1; oMemReq stays 0 for 20 cycles.
- Assert iRstN=0 mid-MEM of SW 0x00112023 -> oMemReq drops immediately, no retire; after release, FETCH with oRetireCnt=0.
- Preload oRetireCnt=all-ones (CNT_W=4, 15 instructions) -> next retire gives 0.
